// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and default width.
`default_nettype none

package counter_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by DIV, producing a one-cycle tick on every DIV-th one.
`default_nettype none

module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  generate
    if (DIV == 1) begin : g_div1
      logic unused_inputs;
      assign unused_inputs = ^{clock, reset, clear};
      assign tick          = enable;
    end else begin : g_divn
      localparam int PW = $clog2(DIV);

      logic [PW-1:0] cnt_q;

      assign tick = enable && (cnt_q == PW'(DIV - 1));

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else if (clear) begin
          cnt_q <= '0;
        end else if (enable) begin
          cnt_q <= tick ? '0 : cnt_q + PW'(1);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/down_counter.sv
// Loadable down counter with prescaled decrement, terminal-count strobe and auto-reload.
`default_nettype none

module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             running,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             running_q;
  logic             done_q;

  logic             presc_en;
  logic             tick;

  // Prescaler only advances while counting; a load restarts its phase.
  assign presc_en = enable && (state_q == ST_RUN) && !load;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (load),
    .enable (presc_en),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        count_q <= load_value;
        done_q  <= 1'b0;
        if (load_value != '0) begin
          reload_q  <= load_value;
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end else begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      end else if ((state_q == ST_RUN) && tick) begin
        if (count_q > WIDTH'(1)) begin
          count_q <= count_q - WIDTH'(1);
        end else if (count_q == WIDTH'(1)) begin
          tc_q <= 1'b1;
          if (auto_reload) begin
            count_q <= reload_q;
          end else begin
            count_q   <= '0;
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
      end
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: one DIV=1 and one DIV=3 instance sharing stimulus.
`default_nettype none
`timescale 1ns/1ps

module tb_down_counter;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       load        = 1'b0;
  logic [3:0] load_value  = 4'd0;
  logic       enable      = 1'b0;
  logic       auto_reload = 1'b0;

  logic [3:0] count1, count3;
  logic       tc1, run1, done1;
  logic       tc3, run3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(4), .DIV(1)) dut1 (
    .clock(clk), .reset(rst_n), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload),
    .count(count1), .tc_pulse(tc1), .running(run1), .done(done1)
  );

  down_counter #(.WIDTH(4), .DIV(3)) dut3 (
    .clock(clk), .reset(rst_n), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload),
    .count(count3), .tc_pulse(tc3), .running(run3), .done(done3)
  );

  // Observed vectors are {count, tc_pulse, running, done}.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_dut1: got %b expected %b", {count1, tc1, run1, done1}, 7'b0000_000);
    end
    checks++;
    if ({count3, tc3, run3, done3} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_dut3: got %b expected %b", {count3, tc3, run3, done3}, 7'b0000_000);
    end
    rst_n = 1'b1;
    enable = 1'b1;
    step();
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL idle_enable_ignored: got %b expected %b", {count1, tc1, run1, done1}, 7'b0000_000);
    end
  endtask

  task automatic test_div1_countdown();
    logic [6:0] exp;
    enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; load_value = 4'd5;
    step();
    load = 1'b0;
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0101_010) begin
      errors++;
      $display("FAIL div1_load: got %b expected %b", {count1, tc1, run1, done1}, 7'b0101_010);
    end
    for (int i = 4; i >= 0; i--) begin
      step();
      exp = {i[3:0], (i == 0), (i != 0), (i == 0)};
      checks++;
      if ({count1, tc1, run1, done1} !== exp) begin
        errors++;
        $display("FAIL div1_count[%0d]: got %b expected %b", i, {count1, tc1, run1, done1}, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({count1, tc1, run1, done1} !== 7'b0000_001) begin
        errors++;
        $display("FAIL div1_done_hold[%0d]: got %b expected %b", i, {count1, tc1, run1, done1}, 7'b0000_001);
      end
    end
  endtask

  task automatic test_div3();
    logic [6:0] exp;
    logic [3:0] c;
    enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; load_value = 4'd2;
    step();
    load = 1'b0;
    checks++;
    if ({count3, tc3, run3, done3} !== 7'b0010_010) begin
      errors++;
      $display("FAIL div3_load: got %b expected %b", {count3, tc3, run3, done3}, 7'b0010_010);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      c   = (k < 3) ? 4'd2 : ((k < 6) ? 4'd1 : 4'd0);
      exp = {c, (k == 6), (k != 6), (k == 6)};
      checks++;
      if ({count3, tc3, run3, done3} !== exp) begin
        errors++;
        $display("FAIL div3_cycle[%0d]: got %b expected %b", k, {count3, tc3, run3, done3}, exp);
      end
    end
    step();
    checks++;
    if ({count3, tc3, run3, done3} !== 7'b0000_001) begin
      errors++;
      $display("FAIL div3_done: got %b expected %b", {count3, tc3, run3, done3}, 7'b0000_001);
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] seq [7] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
    logic [6:0] exp;
    enable = 1'b1; auto_reload = 1'b1;
    load = 1'b1; load_value = 4'd3;
    step();
    load = 1'b0;
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0011_010) begin
      errors++;
      $display("FAIL reload_load: got %b expected %b", {count1, tc1, run1, done1}, 7'b0011_010);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      exp = {seq[i], (seq[i] == 4'd3), 1'b1, 1'b0};
      checks++;
      if ({count1, tc1, run1, done1} !== exp) begin
        errors++;
        $display("FAIL reload_seq[%0d]: got %b expected %b", i, {count1, tc1, run1, done1}, exp);
      end
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_enable_hold();
    enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; load_value = 4'd2;
    step();
    load = 1'b0;
    step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({count3, tc3, run3, done3} !== 7'b0010_010) begin
        errors++;
        $display("FAIL hold_disabled[%0d]: got %b expected %b", i, {count3, tc3, run3, done3}, 7'b0010_010);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if ({count3, tc3, run3, done3} !== 7'b0010_010) begin
      errors++;
      $display("FAIL hold_resume_no_extra: got %b expected %b", {count3, tc3, run3, done3}, 7'b0010_010);
    end
    step();
    checks++;
    if ({count3, tc3, run3, done3} !== 7'b0001_010) begin
      errors++;
      $display("FAIL hold_resume_tick: got %b expected %b", {count3, tc3, run3, done3}, 7'b0001_010);
    end
  endtask

  task automatic test_load_at_expiry();
    enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; load_value = 4'd2;
    step();
    load = 1'b0;
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0001_010) begin
      errors++;
      $display("FAIL expiry_setup: got %b expected %b", {count1, tc1, run1, done1}, 7'b0001_010);
    end
    load = 1'b1; load_value = 4'd9;
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b1001_010) begin
      errors++;
      $display("FAIL load_over_expiry: got %b expected %b", {count1, tc1, run1, done1}, 7'b1001_010);
    end
    load_value = 4'd0;
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL load_zero: got %b expected %b", {count1, tc1, run1, done1}, 7'b0000_000);
    end
    load = 1'b0;
    step();
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL load_zero_idle: got %b expected %b", {count1, tc1, run1, done1}, 7'b0000_000);
    end
  endtask

  task automatic test_reset_midrun();
    enable = 1'b0; auto_reload = 1'b0;
    load = 1'b1; load_value = 4'd7;
    step();
    load = 1'b0;
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0111_010) begin
      errors++;
      $display("FAIL midrun_before_reset: got %b expected %b", {count1, tc1, run1, done1}, 7'b0111_010);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL midrun_async_reset: got %b expected %b", {count1, tc1, run1, done1}, 7'b0000_000);
    end
    #2 rst_n = 1'b1;
    enable = 1'b1;
    step();
    checks++;
    if ({count1, tc1, run1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL midrun_restart_idle: got %b expected %b", {count1, tc1, run1, done1}, 7'b0000_000);
    end
  endtask

  initial begin
    test_reset();
    test_div1_countdown();
    test_div3();
    test_auto_reload();
    test_enable_hold();
    test_load_at_expiry();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
